// File: rtl/ir_camera_poller.sv
// IR camera poller: writes a list of configuration register pairs to the
// camera through an external i2c_master, then polls it continuously and
// decodes up to four blobs per frame. A per-transaction watchdog, short-read
// detection and automatic re-initialisation keep the poller running when the
// bus misbehaves.
module ir_camera_poller #(
  parameter logic [6:0]            I2C_ADDR   = 7'h58,
  parameter int                    NUM_CONF   = 3,
  parameter logic [NUM_CONF*16-1:0] CONF_DATA = 48'h300130083333,
  parameter int                    NUM_BLOBS  = 4,
  parameter int                    READ_BYTES = 16,
  parameter int                    CONF_DELAY = 100,
  parameter int                    POLL_DELAY = 100,
  parameter int                    TIMEOUT    = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [6:0]             i2c_addr,
  output logic                   i2c_rw,
  output logic [4:0]             i2c_packets,
  output logic [7:0]             i2c_data,
  output logic                   i2c_start,
  input  logic                   i2c_ready,
  input  logic                   i2c_data_req,
  input  logic                   i2c_data_ready,
  input  logic [7:0]             i2c_data_in,
  output logic [10*NUM_BLOBS-1:0] blob_x,
  output logic [10*NUM_BLOBS-1:0] blob_y,
  output logic [4*NUM_BLOBS-1:0]  blob_size,
  output logic [NUM_BLOBS-1:0]    blob_valid,
  output logic                   frame_valid,
  output logic                   configured,
  output logic                   error,
  output logic [7:0]             err_count
);

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_CONF_START = 4'd1;
  localparam logic [3:0] ST_CONF_WAIT  = 4'd2;
  localparam logic [3:0] ST_CONF_DELAY = 4'd3;
  localparam logic [3:0] ST_REQ_START  = 4'd4;
  localparam logic [3:0] ST_REQ_WAIT   = 4'd5;
  localparam logic [3:0] ST_READ_START = 4'd6;
  localparam logic [3:0] ST_READ_WAIT  = 4'd7;
  localparam logic [3:0] ST_PROCESS    = 4'd8;
  localparam logic [3:0] ST_POLL_WAIT  = 4'd9;

  // Pair index width; the byte table is padded to a power of two so the
  // {pair, byte} index always addresses a legal entry.
  localparam int PW = (NUM_CONF > 1) ? $clog2(NUM_CONF) : 1;
  localparam int CI = PW + 1;
  localparam int RW = $clog2(READ_BYTES + 1);

  logic [3:0]    state_reg, state_next;
  logic [31:0]   tmr_reg;
  logic [PW-1:0] pair_reg;
  logic          byte_sel_reg;
  logic          reconf_reg;
  logic [RW-1:0] rd_cnt_reg, rd_cnt_next;
  logic [7:0]    i2c_data_reg;
  logic          frame_valid_reg;
  logic          configured_reg;
  logic          error_reg;
  logic [7:0]    err_cnt_reg;

  logic          in_start, in_xfer, in_conf, in_req, in_read;
  logic          timeout_hit, conf_delay_done, poll_done, last_pair;
  logic          cap_en, rd_full, short_read, err_event, load_frame;
  logic          entering;

  logic [7:0]    conf_bytes [2**CI];

  genvar gi;

  // Flatten the configuration word into a byte table, first pair / MSB first.
  generate
    for (gi = 0; gi < 2**CI; gi++) begin : g_conf
      if (gi < 2*NUM_CONF) begin : g_used
        assign conf_bytes[gi] = CONF_DATA[(2*NUM_CONF-1-gi)*8 +: 8];
      end else begin : g_pad
        assign conf_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign in_conf  = (state_reg == ST_CONF_START) || (state_reg == ST_CONF_WAIT);
  assign in_req   = (state_reg == ST_REQ_START)  || (state_reg == ST_REQ_WAIT);
  assign in_read  = (state_reg == ST_READ_START) || (state_reg == ST_READ_WAIT);
  assign in_start = (state_reg == ST_CONF_START) || (state_reg == ST_REQ_START) ||
                    (state_reg == ST_READ_START);
  assign in_xfer  = in_conf || in_req || in_read;

  assign timeout_hit     = in_xfer && (tmr_reg == 32'(TIMEOUT - 1));
  assign conf_delay_done = (tmr_reg == 32'(CONF_DELAY - 1));
  assign poll_done       = (tmr_reg == 32'(POLL_DELAY - 1));
  assign last_pair       = (pair_reg == PW'(NUM_CONF - 1));

  // Read bytes past the requested count are dropped.
  assign cap_en      = i2c_data_ready && in_read && (rd_cnt_reg < RW'(READ_BYTES));
  assign rd_cnt_next = cap_en ? rd_cnt_reg + 1'b1 : rd_cnt_reg;
  assign rd_full     = (rd_cnt_next == RW'(READ_BYTES));
  assign short_read  = (state_reg == ST_READ_WAIT) && i2c_ready && !rd_full;
  assign err_event   = timeout_hit || short_read;
  assign load_frame  = (state_reg == ST_PROCESS);
  assign entering    = (state_next != state_reg);

  assign i2c_addr    = I2C_ADDR;
  assign i2c_start   = in_start;
  assign i2c_data    = i2c_data_reg;
  assign frame_valid = frame_valid_reg;
  assign configured  = configured_reg;
  assign error       = error_reg;
  assign err_count   = err_cnt_reg;

  // Transaction shape is a pure function of the current state.
  always_comb begin
    i2c_rw      = 1'b1;
    i2c_packets = 5'd0;
    if (in_conf) begin
      i2c_rw      = 1'b0;
      i2c_packets = 5'd2;
    end else if (in_req) begin
      i2c_rw      = 1'b0;
      i2c_packets = 5'd1;
    end else if (in_read) begin
      i2c_rw      = 1'b1;
      i2c_packets = 5'(READ_BYTES);
    end
  end

  // Next-state logic; the watchdog overrides every transfer state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (start && i2c_ready) state_next = ST_CONF_START;
      ST_CONF_START: if (!i2c_ready) state_next = ST_CONF_WAIT;
      ST_CONF_WAIT:  if (i2c_ready) state_next = ST_CONF_DELAY;
      ST_CONF_DELAY: if (conf_delay_done) state_next = last_pair ? ST_REQ_START : ST_CONF_START;
      ST_REQ_START:  if (!i2c_ready) state_next = ST_REQ_WAIT;
      ST_REQ_WAIT:   if (i2c_ready) state_next = ST_READ_START;
      ST_READ_START: if (!i2c_ready) state_next = ST_READ_WAIT;
      ST_READ_WAIT:  if (i2c_ready) state_next = rd_full ? ST_PROCESS : ST_POLL_WAIT;
      ST_PROCESS:    state_next = ST_POLL_WAIT;
      ST_POLL_WAIT:  if (poll_done) state_next = reconf_reg ? ST_CONF_START : ST_REQ_START;
      default:       state_next = ST_IDLE;
    endcase
    if (timeout_hit) state_next = ST_POLL_WAIT;
  end

  // Sequencer state, counters, write-byte feed and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      tmr_reg         <= '0;
      pair_reg        <= '0;
      byte_sel_reg    <= 1'b0;
      reconf_reg      <= 1'b0;
      rd_cnt_reg      <= '0;
      i2c_data_reg    <= 8'h00;
      frame_valid_reg <= 1'b0;
      configured_reg  <= 1'b0;
      error_reg       <= 1'b0;
      err_cnt_reg     <= 8'h00;
    end else begin
      state_reg       <= state_next;
      tmr_reg         <= entering ? 32'd0 : tmr_reg + 32'd1;
      frame_valid_reg <= load_frame;

      rd_cnt_reg <= rd_cnt_next;
      if (entering && state_next == ST_READ_START) rd_cnt_reg <= '0;

      if (i2c_data_req && in_conf) begin
        i2c_data_reg <= conf_bytes[{pair_reg, byte_sel_reg}];
        byte_sel_reg <= 1'b1;
      end else if (i2c_data_req && in_req) begin
        i2c_data_reg <= 8'h36;
      end
      if (entering && state_next == ST_CONF_START) byte_sel_reg <= 1'b0;

      if (state_reg == ST_IDLE) pair_reg <= '0;
      if (state_reg == ST_CONF_DELAY && conf_delay_done) begin
        if (last_pair) configured_reg <= 1'b1;
        else           pair_reg       <= pair_reg + 1'b1;
      end

      if (state_reg == ST_POLL_WAIT && poll_done) reconf_reg <= 1'b0;
      if (load_frame) error_reg <= 1'b0;

      if (err_event) begin
        error_reg <= 1'b1;
        if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
      end

      if (timeout_hit) begin
        configured_reg <= 1'b0;
        reconf_reg     <= 1'b1;
        pair_reg       <= '0;
      end
    end
  end

  // Per-blob capture of the three raw bytes and the decoded output registers.
  generate
    for (gi = 0; gi < NUM_BLOBS; gi++) begin : g_blob
      logic [7:0] bx_reg, by_reg, bs_reg;
      logic [9:0] x_reg, y_reg;
      logic [3:0] s_reg;
      logic       v_reg;
      logic [9:0] x_dec, y_dec;

      assign x_dec = {bs_reg[5:4], bx_reg};
      assign y_dec = {bs_reg[7:6], by_reg};

      // Capture raw bytes as they arrive; publish the decode once per frame.
      always_ff @(posedge clk) begin
        if (!reset) begin
          bx_reg <= 8'h00;
          by_reg <= 8'h00;
          bs_reg <= 8'h00;
          x_reg  <= 10'h3FF;
          y_reg  <= 10'h3FF;
          s_reg  <= 4'h0;
          v_reg  <= 1'b0;
        end else begin
          if (cap_en && rd_cnt_reg == RW'(1 + 3*gi)) bx_reg <= i2c_data_in;
          if (cap_en && rd_cnt_reg == RW'(2 + 3*gi)) by_reg <= i2c_data_in;
          if (cap_en && rd_cnt_reg == RW'(3 + 3*gi)) bs_reg <= i2c_data_in;
          if (load_frame) begin
            x_reg <= x_dec;
            y_reg <= y_dec;
            s_reg <= bs_reg[3:0];
            v_reg <= !(x_dec == 10'h3FF && y_dec == 10'h3FF);
          end
        end
      end

      assign blob_x[gi*10 +: 10]  = x_reg;
      assign blob_y[gi*10 +: 10]  = y_reg;
      assign blob_size[gi*4 +: 4] = s_reg;
      assign blob_valid[gi]       = v_reg;
    end
  endgenerate

endmodule
